// File: rtl/pwr_seq_ctrl.sv
// Five-rail power sequencer: staged rail bring-up/tear-down handshaked with an external delay timer.
// Optional per-wait watchdog enabled by defining PWR_SEQ_WDOG_EN (timeout = WDOG_CYCLES clocks).
module pwr_seq_ctrl #(
    parameter int WDOG_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       shutdown,
    input  logic       clear_fault,
    input  logic [4:0] T,
    input  logic [4:0] pgood,
    output logic       ld,
    output logic [4:0] sel,
    output logic [4:0] rail_en,
    output logic       busy,
    output logic       pwr_on,
    output logic       fault
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_UP_LOAD  = 3'd1;
    localparam logic [2:0] S_UP_WAIT  = 3'd2;
    localparam logic [2:0] S_UP_CHECK = 3'd3;
    localparam logic [2:0] S_ON       = 3'd4;
    localparam logic [2:0] S_DN_LOAD  = 3'd5;
    localparam logic [2:0] S_DN_WAIT  = 3'd6;
    localparam logic [2:0] S_FAULT    = 3'd7;

    logic [2:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       abort_q, abort_d;
    logic       ld_q, ld_d;
    logic [4:0] sel_q, sel_d;
    logic [4:0] rail_en_q, rail_en_d;
    logic       busy_q, busy_d;
    logic       pwr_on_q, pwr_on_d;
    logic       fault_q, fault_d;
    logic [4:0] stage_bit;
    logic       done_hit;
    logic       done_bad;
    logic       wdog_expire;

    assign done_hit = (T == sel_q);
    assign done_bad = (T != 5'b00000) && !done_hit;

`ifdef PWR_SEQ_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    logic [WDW-1:0] wdog_q, wdog_d;

    assign wdog_expire = (32'(wdog_q) + 32'd1) >= 32'(WDOG_CYCLES);

    // Counter restarts on every entry into a wait state and only runs while staying there.
    always_comb begin
        wdog_d = '0;
        if ((state_q == S_UP_WAIT && state_d == S_UP_WAIT) ||
            (state_q == S_DN_WAIT && state_d == S_DN_WAIT)) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        abort_d   = abort_q;
        sel_d     = sel_q;
        rail_en_d = rail_en_q;

        case (state_q)
            S_IDLE: begin
                if (start && !shutdown) begin
                    state_d = S_UP_LOAD;
                    idx_d   = 3'd0;
                end
            end
            S_UP_LOAD: begin
                state_d = S_UP_WAIT;
                abort_d = shutdown;
            end
            S_UP_WAIT: begin
                // An abort still waits here for the loaded stage's done so the timer is idle before the next ld.
                if (done_bad) begin
                    state_d = S_FAULT;
                end else if (done_hit) begin
                    state_d = (abort_q || shutdown) ? S_DN_LOAD : S_UP_CHECK;
                end else if (wdog_expire) begin
                    state_d = S_FAULT;
                end else if (shutdown) begin
                    abort_d = 1'b1;
                end
            end
            S_UP_CHECK: begin
                if (!pgood[idx_q]) begin
                    state_d = S_FAULT;
                end else if (shutdown) begin
                    state_d = S_DN_LOAD;
                end else if (idx_q == 3'd4) begin
                    state_d = S_ON;
                end else begin
                    state_d = S_UP_LOAD;
                    idx_d   = idx_q + 3'd1;
                end
            end
            S_ON: begin
                if ((pgood & rail_en_q) != rail_en_q) begin
                    state_d = S_FAULT;
                end else if (shutdown) begin
                    state_d = S_DN_LOAD;
                    idx_d   = 3'd4;
                end
            end
            S_DN_LOAD: begin
                state_d = S_DN_WAIT;
            end
            S_DN_WAIT: begin
                if (done_bad) begin
                    state_d = S_FAULT;
                end else if (done_hit) begin
                    if (idx_q == 3'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DN_LOAD;
                        idx_d   = idx_q - 3'd1;
                    end
                end else if (wdog_expire) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                if (clear_fault) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        if (state_d == S_IDLE) begin
            idx_d = 3'd0;
        end
        if (state_d != S_UP_WAIT) begin
            abort_d = 1'b0;
        end

        // Registered outputs are derived from the state being entered.
        stage_bit = 5'b00001 << idx_d;
        ld_d      = (state_d == S_UP_LOAD) || (state_d == S_DN_LOAD);
        if (ld_d) begin
            sel_d = stage_bit;
        end
        if (state_d == S_IDLE || state_d == S_ON || state_d == S_FAULT) begin
            sel_d = 5'b00000;
        end
        if (state_d == S_UP_LOAD) begin
            rail_en_d = rail_en_q | stage_bit;
        end
        if (state_d == S_DN_LOAD) begin
            rail_en_d = rail_en_q & ~stage_bit;
        end
        if (state_d == S_ON) begin
            rail_en_d = 5'b11111;
        end
        if (state_d == S_FAULT) begin
            rail_en_d = 5'b00000;
        end
        busy_d   = !(state_d == S_IDLE || state_d == S_ON || state_d == S_FAULT);
        pwr_on_d = (state_d == S_ON);
        fault_d  = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            abort_q   <= 1'b0;
            ld_q      <= 1'b0;
            sel_q     <= 5'b00000;
            rail_en_q <= 5'b00000;
            busy_q    <= 1'b0;
            pwr_on_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            abort_q   <= abort_d;
            ld_q      <= ld_d;
            sel_q     <= sel_d;
            rail_en_q <= rail_en_d;
            busy_q    <= busy_d;
            pwr_on_q  <= pwr_on_d;
            fault_q   <= fault_d;
        end
    end

    assign ld      = ld_q;
    assign sel     = sel_q;
    assign rail_en = rail_en_q;
    assign busy    = busy_q;
    assign pwr_on  = pwr_on_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Self-checking bench for pwr_seq_ctrl: vector table, directed multi-cycle scenarios,
// and random stimulus against a phase-level reference model.
module tb_pwr_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, shutdown, clear_fault;
    logic [4:0] T, pgood;
    logic       ld, busy, pwr_on, fault;
    logic [4:0] sel, rail_en;

    pwr_seq_ctrl #(.WDOG_CYCLES(15)) dut (
        .clk(clk), .reset(reset), .start(start), .shutdown(shutdown),
        .clear_fault(clear_fault), .T(T), .pgood(pgood), .ld(ld), .sel(sel),
        .rail_en(rail_en), .busy(busy), .pwr_on(pwr_on), .fault(fault)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_out();
        return {19'd0, ld, sel, rail_en, busy, pwr_on, fault};
    endfunction

    typedef logic [4:0] selq_t [$];
    function automatic logic [31:0] qpack(input selq_t q);
        logic [31:0] r;
        r = 32'(q.size()) << 25;
        for (int i = 0; i < q.size() && i < 5; i++) r[24:0] = {r[19:0], q[i]};
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef enum int {P_IDLE, P_UPL, P_UPW, P_UPC, P_ON, P_DNL, P_DNW, P_FLT} phase_t;
    phase_t     m_ph;
    int         m_stage, m_wd;
    bit         m_abort;
    logic [4:0] m_rails;
`ifdef PWR_SEQ_WDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif
    localparam int WD_LIMIT = 15;

    function automatic logic [4:0] onehot(input int i);
        return 5'(1 << i);
    endfunction

    function automatic void m_go(input phase_t p, input int stg);
        m_ph = p; m_stage = stg; m_abort = 1'b0; m_wd = 0;
        if (p == P_UPL) m_rails = m_rails | onehot(stg);
        if (p == P_DNL) m_rails = m_rails & ~onehot(stg);
        if (p == P_ON)  m_rails = 5'h1f;
        if (p == P_FLT) m_rails = 5'h00;
    endfunction

    function automatic void m_reset();
        m_rails = 5'h00;
        m_go(P_IDLE, 0);
    endfunction

    function automatic void m_step(input logic st, input logic sd, input logic cf,
                                   input logic [4:0] t, input logic [4:0] pg);
        logic [4:0] s;
        s = onehot(m_stage);
        case (m_ph)
            P_IDLE: if (st && !sd) m_go(P_UPL, 0);
            P_UPL: begin m_go(P_UPW, m_stage); m_abort = sd; end
            P_UPW, P_DNW: begin
                if (t != 5'd0 && t != s) m_go(P_FLT, m_stage);
                else if (t == s) begin
                    if (m_ph == P_DNW) begin
                        if (m_stage == 0) m_go(P_IDLE, 0); else m_go(P_DNL, m_stage - 1);
                    end else if (m_abort || sd) m_go(P_DNL, m_stage);
                    else m_go(P_UPC, m_stage);
                end else begin
                    m_wd++;
                    if (sd && m_ph == P_UPW) m_abort = 1'b1;
                    if (WD_ON && m_wd >= WD_LIMIT) m_go(P_FLT, m_stage);
                end
            end
            P_UPC: begin
                if (!pg[m_stage]) m_go(P_FLT, m_stage);
                else if (sd) m_go(P_DNL, m_stage);
                else if (m_stage == 4) m_go(P_ON, 4);
                else m_go(P_UPL, m_stage + 1);
            end
            P_ON: begin
                if (pg != 5'h1f) m_go(P_FLT, m_stage);
                else if (sd) m_go(P_DNL, 4);
            end
            P_DNL: m_go(P_DNW, m_stage);
            P_FLT: if (cf) m_go(P_IDLE, 0);
            default: m_go(P_IDLE, 0);
        endcase
    endfunction

    function automatic logic [31:0] m_out();
        logic e_ld, e_busy;
        logic [4:0] e_sel;
        e_ld   = (m_ph == P_UPL) || (m_ph == P_DNL);
        e_busy = !(m_ph == P_IDLE || m_ph == P_ON || m_ph == P_FLT);
        e_sel  = e_busy ? onehot(m_stage) : 5'd0;
        return {19'd0, e_ld, e_sel, m_rails, e_busy, m_ph == P_ON, m_ph == P_FLT};
    endfunction

    // ---------------- timer / pgood emulation for directed scenarios ----------------
    bit         tmr_auto = 1'b0, pg_follow = 1'b0, prev_ld = 1'b0;
    int         tmr_cnt = 0, tmr_delay = 6, ld_consec = 0;
    logic [4:0] tmr_sel = 5'd0, pg_mask = 5'h1f;

    task automatic tick();
        @(posedge clk);
        #1;
        if (ld && prev_ld) ld_consec++;
        prev_ld = ld;
        if (tmr_auto) begin
            T = 5'd0;
            if (tmr_cnt > 0) begin
                tmr_cnt--;
                if (tmr_cnt == 0) T = tmr_sel;
            end
            if (ld) begin
                tmr_cnt = tmr_delay;
                tmr_sel = sel;
            end
        end
        if (pg_follow) pgood = rail_en & pg_mask;
    endtask

    typedef struct {
        logic st, sd, cf;
        logic [4:0] t, pg;
        logic e_ld;
        logic [4:0] e_sel, e_rail;
        logic e_busy, e_on, e_flt;
    } vec_t;
    vec_t vecs[15];

    selq_t got_q, exp_q;
    int n, bad, early;
    bit t_fired;
    logic [4:0] last_sel, nt, pg;

    initial begin
        vecs = '{
            '{1'b1,1'b0,1'b0,5'b00000,5'h1f, 1'b1,5'b00001,5'b00001,1'b1,1'b0,1'b0},
            '{1'b0,1'b0,1'b0,5'b00000,5'h1f, 1'b0,5'b00001,5'b00001,1'b1,1'b0,1'b0},
            '{1'b0,1'b0,1'b0,5'b00001,5'h1f, 1'b0,5'b00001,5'b00001,1'b1,1'b0,1'b0},
            '{1'b0,1'b0,1'b0,5'b00000,5'h1f, 1'b1,5'b00010,5'b00011,1'b1,1'b0,1'b0},
            '{1'b0,1'b0,1'b0,5'b00000,5'h1f, 1'b0,5'b00010,5'b00011,1'b1,1'b0,1'b0},
            '{1'b0,1'b0,1'b0,5'b00100,5'h1f, 1'b0,5'b00000,5'b00000,1'b0,1'b0,1'b1},
            '{1'b0,1'b0,1'b1,5'b00000,5'h1f, 1'b0,5'b00000,5'b00000,1'b0,1'b0,1'b0},
            '{1'b1,1'b1,1'b0,5'b00000,5'h1f, 1'b0,5'b00000,5'b00000,1'b0,1'b0,1'b0},
            '{1'b1,1'b0,1'b0,5'b00000,5'h1f, 1'b1,5'b00001,5'b00001,1'b1,1'b0,1'b0},
            '{1'b0,1'b1,1'b0,5'b00000,5'h1f, 1'b0,5'b00001,5'b00001,1'b1,1'b0,1'b0},
            '{1'b0,1'b0,1'b0,5'b00000,5'h1f, 1'b0,5'b00001,5'b00001,1'b1,1'b0,1'b0},
            '{1'b0,1'b0,1'b0,5'b00001,5'h1f, 1'b1,5'b00001,5'b00000,1'b1,1'b0,1'b0},
            '{1'b0,1'b0,1'b0,5'b00000,5'h1f, 1'b0,5'b00001,5'b00000,1'b1,1'b0,1'b0},
            '{1'b0,1'b0,1'b0,5'b00001,5'h1f, 1'b0,5'b00000,5'b00000,1'b0,1'b0,1'b0},
            '{1'b0,1'b0,1'b0,5'b00010,5'h1f, 1'b0,5'b00000,5'b00000,1'b0,1'b0,1'b0}
        };

        reset = 1'b0; start = 1'b0; shutdown = 1'b0; clear_fault = 1'b0;
        T = 5'd0; pgood = 5'd0;
        tick(); tick();
        chk("reset_outputs", dut_out(), 32'd0);
        reset = 1'b1;

        // vector table
        for (int i = 0; i < 15; i++) begin
            start = vecs[i].st; shutdown = vecs[i].sd; clear_fault = vecs[i].cf;
            T = vecs[i].t; pgood = vecs[i].pg;
            tick();
            chk($sformatf("vec%0d", i), dut_out(),
                {19'd0, vecs[i].e_ld, vecs[i].e_sel, vecs[i].e_rail,
                 vecs[i].e_busy, vecs[i].e_on, vecs[i].e_flt});
        end
        start = 1'b0; shutdown = 1'b0; clear_fault = 1'b0; T = 5'd0;
        tmr_auto = 1'b1; pg_follow = 1'b1; pg_mask = 5'h1f; tmr_cnt = 0;

        // full power-up
        got_q = {}; start = 1'b1;
        for (n = 0; n < 300; n++) begin
            tick();
            start = 1'b0;
            if (ld) got_q.push_back(sel);
            if (pwr_on) break;
        end
        exp_q = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
        chk("pu_sel_order", qpack(got_q), qpack(exp_q));
        chk("pu_on_state", {pwr_on, rail_en, busy, fault}, {1'b1, 5'b11111, 1'b0, 1'b0});

        // full power-down
        got_q = {}; bad = 0; shutdown = 1'b1;
        for (n = 0; n < 300; n++) begin
            tick();
            shutdown = 1'b0;
            if (ld) begin
                got_q.push_back(sel);
                if (rail_en != sel - 5'd1) bad++;
            end
            if (!busy) break;
        end
        exp_q = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
        chk("pd_sel_order", qpack(got_q), qpack(exp_q));
        chk("pd_rail_steps", bad, 0);
        chk("pd_idle", dut_out(), 32'd0);

        // pgood[2] never rises
        pg_mask = 5'b11011; last_sel = 5'd0; start = 1'b1;
        for (n = 0; n < 300; n++) begin
            tick();
            start = 1'b0;
            if (ld) last_sel = sel;
            if (fault) break;
        end
        chk("pgf_state", {fault, rail_en, busy, pwr_on, sel}, {1'b1, 5'b00000, 1'b0, 1'b0, 5'b00000});
        chk("pgf_stage", last_sel, 5'b00100);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("pgf_clear", dut_out(), 32'd0);
        pg_mask = 5'h1f;

        // abort during stage-2 wait
        start = 1'b1;
        for (n = 0; n < 300; n++) begin
            tick();
            start = 1'b0;
            if (ld && sel == 5'b00100) break;
        end
        tick();
        shutdown = 1'b1;
        tick();
        shutdown = 1'b0;
        got_q = {}; early = 0; t_fired = 1'b0;
        for (n = 0; n < 300; n++) begin
            tick();
            if (ld && !t_fired) early++;
            if (ld) got_q.push_back(sel);
            if (T == 5'b00100) t_fired = 1'b1;
            if (!busy) break;
        end
        exp_q = '{5'b00100, 5'b00010, 5'b00001};
        chk("abort_early_ld", early, 0);
        chk("abort_sel_order", qpack(got_q), qpack(exp_q));
        chk("abort_idle", dut_out(), 32'd0);

        // asynchronous reset in the middle of a wait, then restart from IDLE
        start = 1'b1;
        for (n = 0; n < 300; n++) begin
            tick();
            start = 1'b0;
            if (ld && sel == 5'b00010) break;
        end
        tick(); tick();
        #3 reset = 1'b0;
        #1 chk("rst_async_clear", dut_out(), 32'd0);
        tick(); tick();
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dut_out() != 32'd0) bad++;
        end
        chk("rst_stays_idle", bad, 0);

`ifdef PWR_SEQ_WDOG_EN
        tmr_auto = 1'b0; T = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n = 0;
        while (!fault && n < 100) begin
            tick();
            n++;
        end
        chk("wdog_latency", n, 15);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #3 reset = 1'b0;
        #1 chk("wdog_rst_async", dut_out(), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("wdog_rst_idle", dut_out(), 32'd0);
`endif

        chk("ld_not_consecutive", ld_consec, 0);

        // randomized run against the reference model
        tmr_auto = 1'b0; pg_follow = 1'b0;
        reset = 1'b0; start = 1'b0; shutdown = 1'b0; clear_fault = 1'b0;
        T = 5'd0; pgood = 5'd0;
        tick(); tick();
        reset = 1'b1;
        m_reset();
        tmr_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            m_step(start, shutdown, clear_fault, T, pgood);
            #1;
            chk($sformatf("rand_c%0d", c), dut_out(), m_out());
            nt = 5'd0;
            if (tmr_cnt > 0) begin
                tmr_cnt--;
                if (tmr_cnt == 0) nt = tmr_sel;
            end
            if (m_out() & 32'h1000) begin
                tmr_cnt = $urandom_range(1, 10);
                tmr_sel = onehot(m_stage);
            end
            if ($urandom_range(0, 79) == 0) nt = onehot($urandom_range(0, 4));
            pg = m_rails;
            if ($urandom_range(0, 99) == 0) pg = pg ^ onehot($urandom_range(0, 4));
            T = nt;
            pgood = pg;
            start = ($urandom_range(0, 3) == 0);
            shutdown = ($urandom_range(0, 59) == 0);
            clear_fault = ($urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
